// File: rtl/result_collector.sv
// Drain-side collector for the systolic-array south edge: de-skews four staggered
// output lanes into a 4x4 result memory, flags completion and serves random reads.
`timescale 1ns/1ps
module result_collector #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          TRANSPOSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  input  logic [WIDTH-1:0] q3,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem    [16];
  logic [WIDTH-1:0] lane_q [4];
  logic [1:0]       idx    [4];
  logic [3:1]       wr_r;
  logic [3:0]       we;
  logic             wr_gated;
  logic [2:0]       n_wr;
  logic [4:0]       count, count_nxt;

  function automatic logic [3:0] elem_addr(input logic [1:0] lane, input logic [1:0] slot);
    return TRANSPOSE ? {slot, lane} : {lane, slot};
  endfunction

  always_comb begin
    lane_q[0] = q0;
    lane_q[1] = q1;
    lane_q[2] = q2;
    lane_q[3] = q3;
  end

  // Only the strobe is delayed; lane k writes whatever qk carries on its strobe cycle.
  always_comb begin
    wr_gated  = wr_en && (state != DONE) && !clear;
    we        = {wr_r[3], wr_r[2], wr_r[1], wr_gated} & {4{~clear}};
    n_wr      = '0;
    for (int unsigned k = 0; k < 4; k++) n_wr = n_wr + 3'(we[k]);
    count_nxt = count + 5'(n_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = IDLE;
               else if (wr_en) state_nxt = COLLECT;
      COLLECT: if (clear) state_nxt = IDLE;
               else if (count_nxt == 5'd16) state_nxt = DONE;
      DONE:    if (clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r    <= '0;
      count   <= '0;
      err     <= 1'b0;
      rd_data <= '0;
      for (int unsigned k = 0; k < 4; k++) idx[k] <= '0;
    end else begin
      if (clear) begin
        wr_r  <= '0;
        count <= '0;
        err   <= 1'b0;
        for (int unsigned k = 0; k < 4; k++) idx[k] <= '0;
      end else begin
        wr_r  <= {wr_r[2:1], wr_gated};
        count <= count_nxt;
        for (int unsigned k = 0; k < 4; k++)
          if (we[k]) idx[k] <= idx[k] + 2'd1;
        if (wr_en && state == DONE) err <= 1'b1;
      end
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end

  // Storage is deliberately left out of reset; contents survive reset and clear.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 4; k++)
      if (we[k]) mem[elem_addr(2'(k), idx[k])] <= lane_q[k];
  end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: drives both TRANSPOSE variants with shared
// stimulus and scores read data against a reference memory via an expected-read queue.
`timescale 1ns/1ps
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst_n, wr_en, clear, rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] qv [4];
  logic [31:0] rd_data0, rd_data1;
  logic        done0, done1, err0, err1;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] e0;
    logic [31:0] e1;
  } rd_exp_t;

  rd_exp_t     sb [$];
  logic [31:0] m0 [16];
  logic [31:0] m1 [16];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  result_collector #(.WIDTH(32), .TRANSPOSE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .q0(qv[0]), .q1(qv[1]), .q2(qv[2]), .q3(qv[3]),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .done(done0), .err(err0)
  );

  result_collector #(.WIDTH(32), .TRANSPOSE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .q0(qv[0]), .q1(qv[1]), .q2(qv[2]), .q3(qv[3]),
    .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .done(done1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_q();
    for (int k = 0; k < 4; k++) qv[k] = $urandom;
  endtask

  task automatic pop_check();
    rd_exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      check($sformatf("rd0_a%0d", e.addr), rd_data0, e.e0);
      check($sformatf("rd1_a%0d", e.addr), rd_data1, e.e1);
    end
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    repeat (n) begin
      randomize_q();
      @(posedge clk); #1;
    end
  endtask

  task automatic read_one(input int a);
    rd_en   = 1'b1;
    rd_addr = 4'(a);
    sb.push_back(rd_exp_t'{4'(a), m0[a], m1[a]});
    randomize_q();
    @(posedge clk); #1;
    pop_check();
    rd_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) read_one(a);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_done0", done0, 0);
    check("clr_err0",  err0,  0);
    check("clr_done1", done1, 0);
  endtask

  // Lane k carries element 0x100*k+slot+salt exactly on the cycles its delayed strobe fires;
  // every other cycle it carries random junk that must never land in memory.
  task automatic send(input logic [15:0] pat, input int len, input logic [31:0] salt,
                      input int ncyc, input int rd_at, input logic [3:0] ra);
    logic [1:0]  sl [4];
    logic [31:0] v;
    int          j;
    for (int k = 0; k < 4; k++) sl[k] = 2'd0;
    for (int c = 0; c < ncyc; c++) begin
      wr_en   = (c < len) && pat[c];
      rd_en   = (c == rd_at);
      rd_addr = ra;
      if (c == rd_at) sb.push_back(rd_exp_t'{ra, m0[ra], m1[ra]});
      randomize_q();
      for (int k = 0; k < 4; k++) begin
        j = c - k;
        if (j >= 0 && j < len && pat[j]) begin
          v = 32'h100 * k + 32'(sl[k]) + salt;
          qv[k] = v;
          m0[{2'(k), sl[k]}] = v;
          m1[{sl[k], 2'(k)}] = v;
          sl[k] = sl[k] + 2'd1;
        end
      end
      @(posedge clk); #1;
      if (c == rd_at) pop_check();
      if (ncyc >= len + 3) begin
        check($sformatf("done0_c%0d", c), done0, (c >= len + 2) ? 1 : 0);
        check($sformatf("done1_c%0d", c), done1, (c >= len + 2) ? 1 : 0);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
    randomize_q();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done0", done0, 0);
    check("rst_err0",  err0,  0);
    check("rst_rd0",   rd_data0, 0);
    check("rst_done1", done1, 0);
    check("rst_rd1",   rd_data1, 0);
    rst_n = 1'b1;
    idle(2);

    // Contiguous matrix, both address mappings
    send(16'hF, 4, 32'h0, 7, -1, 4'd0);
    check("t1_err0", err0, 0);
    read_all();
    do_clear();

    // Gapped strobe 1,0,1,1,0,1
    idle(1);
    send(16'b101101, 6, 32'h5000, 9, -1, 4'd0);
    read_all();

    // Write attempt while done: dropped, err sticky
    wr_en = 1'b1;
    randomize_q();
    qv[0] = 32'hDEAD;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check("t4_err0",  err0,  1);
    check("t4_err1",  err1,  1);
    check("t4_done0", done0, 1);
    idle(3);
    check("t4_err0_sticky", err0, 1);
    read_one(0);
    do_clear();
    send(16'hF, 4, 32'h7000, 7, -1, 4'd0);
    read_all();
    do_clear();

    // Reset mid-collect, then a full clean matrix
    send(16'hF, 4, 32'h3000, 2, -1, 4'd0);
    rst_n = 1'b0;
    idle(2);
    check("t5_done0", done0, 0);
    check("t5_rd0",   rd_data0, 0);
    rst_n = 1'b1;
    idle(3);
    send(16'hF, 4, 32'h9000, 7, -1, 4'd0);
    read_all();
    do_clear();

    // Read of addr 5 on the edge lane 1 writes it returns the old value
    send(16'hF, 4, 32'h10, 7, 2, 4'd5);
    read_one(5);
    check("t6_new0", rd_data0, 32'h111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
